// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcodes, function codes, ALU op bit indices and ID->EX field widths
// Shared by the decode stage, its interface and the load scoreboard.
package id_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int ALU_OP_W = 12;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI  = 6'h0c,
                         OP_ORI     = 6'h0d, OP_XORI   = 6'h0e, OP_LUI   = 6'h0f, OP_LW    = 6'h23,
                         OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

  // One-hot ALU op bit positions, MSB first: {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  localparam int ALU_LUI = 0, ALU_SRA = 1, ALU_SRL = 2, ALU_SLL = 3, ALU_XOR = 4, ALU_OR  = 5,
                 ALU_NOR = 6, ALU_AND = 7, ALU_SLTU = 8, ALU_SLT = 9, ALU_SUB = 10, ALU_ADD = 11;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 4;

  function automatic bit load_lat_ok(int lat);
    return (lat >= LOAD_LAT_MIN) && (lat <= LOAD_LAT_MAX);
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_onehot(int idx);
    return ALU_OP_W'(1) << idx;
  endfunction

endpackage

// File: rtl/id_stage_v2_if.sv
// rtl/id_stage_v2_if.sv - decoded ID->EX slot bundle (decode drives as master, EX reads as slave)
interface id_stage_v2_if;
  import id_pkg::*;

  logic                ex_valid;
  logic [DATA_W-1:0]   ex_pc;
  logic [DATA_W-1:0]   ex_inst;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_rf_we;
  logic [REG_W-1:0]    ex_rf_waddr;
  logic                ex_is_load;
  logic                ex_mem_we;
  logic [DATA_W-1:0]   ex_rs_val;
  logic [DATA_W-1:0]   ex_rt_val;
  logic                br_taken;
  logic [DATA_W-1:0]   br_target;

  modport master (
    output ex_valid, ex_pc, ex_inst, ex_alu_op, ex_rf_we, ex_rf_waddr,
           ex_is_load, ex_mem_we, ex_rs_val, ex_rt_val, br_taken, br_target
  );

  modport slave (
    input  ex_valid, ex_pc, ex_inst, ex_alu_op, ex_rf_we, ex_rf_waddr,
           ex_is_load, ex_mem_we, ex_rs_val, ex_rt_val, br_taken, br_target
  );

endinterface

// File: rtl/id_load_sb.sv
// rtl/id_load_sb.sv - load shadow scoreboard: LOAD_LAT-deep shift of in-flight load destinations
// Two query ports report whether a register is still owned by a load that cannot be forwarded yet.
module id_load_sb
  import id_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             ld_issue,
  input  logic [REG_W-1:0] ld_waddr,
  input  logic [REG_W-1:0] q0_addr,
  input  logic [REG_W-1:0] q1_addr,
  output logic             q0_hit,
  output logic             q1_hit
);

  if (!load_lat_ok(LOAD_LAT)) begin : g_lat_check
    $error("id_load_sb: LOAD_LAT must be within 1..4");
  end

  logic             stg_vld  [LOAD_LAT];
  logic [REG_W-1:0] stg_addr [LOAD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        stg_vld[i]  <= 1'b0;
        stg_addr[i] <= '0;
      end
    end else if (advance) begin
      stg_vld[0]  <= ld_issue;
      stg_addr[0] <= ld_waddr;
      for (int i = 1; i < LOAD_LAT; i++) begin
        stg_vld[i]  <= stg_vld[i-1];
        stg_addr[i] <= stg_addr[i-1];
      end
    end
  end

  // r0 is hardwired, so a load targeting it never blocks anyone
  always_comb begin
    q0_hit = 1'b0;
    q1_hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (stg_vld[i] && (stg_addr[i] == q0_addr) && (q0_addr != '0)) q0_hit = 1'b1;
      if (stg_vld[i] && (stg_addr[i] == q1_addr) && (q1_addr != '0)) q1_hit = 1'b1;
    end
  end

endmodule

// File: rtl/id_stage_v2.sv
// rtl/id_stage_v2.sv - MIPS decode stage: ID register, SRAM hold buffer, forwarding, branch resolve, load interlock
// Define BRANCH_EXT_EN to decode bltz/bgez/bltzal/bgezal/blez/bgtz; otherwise those decode as NOP.
module id_stage_v2
  import id_pkg::*;
#(
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_stall,
  input  logic                      id_flush,
  input  logic                      ex_stall,
  input  logic                      if_valid,
  input  logic [DATA_W-1:0]         if_pc,
  input  logic [DATA_W-1:0]         inst_rdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [REG_W*NUM_FWD-1:0]  fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
  input  logic                      wb_we,
  input  logic [REG_W-1:0]          wb_waddr,
  input  logic [DATA_W-1:0]         wb_wdata,
  output logic                      stallreq,
  id_stage_v2_if.master             ex
);

  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic              hold_vld;
  logic [DATA_W-1:0] hold_inst;
  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (id_flush) begin
      id_valid <= 1'b0;
    end else if (!id_stall) begin
      id_valid <= if_valid;
      id_pc    <= if_pc;
    end
  end

  // The SRAM word for the ID pc only appears for one cycle; keep it while ID is held
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld  <= 1'b0;
      hold_inst <= '0;
    end else if (id_flush) begin
      hold_vld <= 1'b0;
    end else if (id_stall && !hold_vld) begin
      hold_vld  <= 1'b1;
      hold_inst <= inst_rdata;
    end else if (!id_stall) begin
      hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && (wb_waddr != '0)) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  logic [DATA_W-1:0] inst;
  logic [5:0]        op, func;
  logic [REG_W-1:0]  rs, rt, rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] pc4, b_tgt, j_tgt;

  assign inst  = hold_vld ? hold_inst : inst_rdata;
  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign func  = inst[5:0];
  assign imm   = inst[15:0];
  assign pc4   = id_pc + 32'd4;
  assign b_tgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_tgt = {pc4[31:28], inst[25:0], 2'b00};

  logic [REG_W-1:0]  fwd_addr_a [NUM_FWD];
  logic [DATA_W-1:0] fwd_data_a [NUM_FWD];

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
    assign fwd_addr_a[g] = fwd_waddr[REG_W*g +: REG_W];
    assign fwd_data_a[g] = fwd_wdata[DATA_W*g +: DATA_W];
  end

  logic [DATA_W-1:0] rs_val, rt_val;

  // Apply sources oldest first so the youngest match is the one left standing
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (wb_we && (wb_waddr == rs)) rs_val = wb_wdata;
    if (wb_we && (wb_waddr == rt)) rt_val = wb_wdata;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_addr_a[i] == rs)) rs_val = fwd_data_a[i];
      if (fwd_we[i] && (fwd_addr_a[i] == rt)) rt_val = fwd_data_a[i];
    end
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
  end

  logic [ALU_OP_W-1:0] d_alu;
  logic                d_we, d_load, d_mem_we, d_br, rs_used, rt_used;
  logic [REG_W-1:0]    d_waddr;
  logic [DATA_W-1:0]   d_tgt;

  always_comb begin
    d_alu    = '0;
    d_we     = 1'b0;
    d_waddr  = '0;
    d_load   = 1'b0;
    d_mem_we = 1'b0;
    d_br     = 1'b0;
    d_tgt    = '0;
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    case (op)
      OP_SPECIAL: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
        d_we    = 1'b1;
        d_waddr = rd;
        case (func)
          FN_SLL:  begin d_alu = alu_onehot(ALU_SLL); rs_used = 1'b0; end
          FN_SRL:  begin d_alu = alu_onehot(ALU_SRL); rs_used = 1'b0; end
          FN_SRA:  begin d_alu = alu_onehot(ALU_SRA); rs_used = 1'b0; end
          FN_SLLV: d_alu = alu_onehot(ALU_SLL);
          FN_SRLV: d_alu = alu_onehot(ALU_SRL);
          FN_SRAV: d_alu = alu_onehot(ALU_SRA);
          FN_ADDU: d_alu = alu_onehot(ALU_ADD);
          FN_SUBU: d_alu = alu_onehot(ALU_SUB);
          FN_AND:  d_alu = alu_onehot(ALU_AND);
          FN_OR:   d_alu = alu_onehot(ALU_OR);
          FN_XOR:  d_alu = alu_onehot(ALU_XOR);
          FN_NOR:  d_alu = alu_onehot(ALU_NOR);
          FN_SLT:  d_alu = alu_onehot(ALU_SLT);
          FN_SLTU: d_alu = alu_onehot(ALU_SLTU);
          FN_JR:   begin rt_used = 1'b0; d_we = 1'b0; d_waddr = '0; d_br = 1'b1; d_tgt = rs_val; end
          FN_JALR: begin rt_used = 1'b0; d_alu = alu_onehot(ALU_ADD); d_br = 1'b1; d_tgt = rs_val; end
          default: begin rs_used = 1'b0; rt_used = 1'b0; d_we = 1'b0; d_waddr = '0; end
        endcase
      end
      OP_J:   begin d_br = 1'b1; d_tgt = j_tgt; end
      OP_JAL: begin d_br = 1'b1; d_tgt = j_tgt; d_we = 1'b1; d_waddr = 5'd31; d_alu = alu_onehot(ALU_ADD); end
      OP_BEQ: begin rs_used = 1'b1; rt_used = 1'b1; d_br = (rs_val == rt_val); d_tgt = b_tgt; end
      OP_BNE: begin rs_used = 1'b1; rt_used = 1'b1; d_br = (rs_val != rt_val); d_tgt = b_tgt; end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        rs_used = 1'b1;
        d_we    = 1'b1;
        d_waddr = rt;
        case (op)
          OP_ADDIU: d_alu = alu_onehot(ALU_ADD);
          OP_SLTI:  d_alu = alu_onehot(ALU_SLT);
          OP_SLTIU: d_alu = alu_onehot(ALU_SLTU);
          OP_ANDI:  d_alu = alu_onehot(ALU_AND);
          OP_ORI:   d_alu = alu_onehot(ALU_OR);
          default:  d_alu = alu_onehot(ALU_XOR);
        endcase
      end
      OP_LUI: begin d_alu = alu_onehot(ALU_LUI); d_we = 1'b1; d_waddr = rt; end
      OP_LW:  begin rs_used = 1'b1; d_we = 1'b1; d_waddr = rt; d_load = 1'b1; d_alu = alu_onehot(ALU_ADD); end
      OP_SW:  begin rs_used = 1'b1; rt_used = 1'b1; d_mem_we = 1'b1; d_alu = alu_onehot(ALU_ADD); end
`ifdef BRANCH_EXT_EN
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: begin
            rs_used = 1'b1;
            d_br    = rt[0] ? !rs_val[31] : rs_val[31];
            d_tgt   = b_tgt;
            // Linking forms write r31 whether or not the branch is taken
            if (rt[4]) begin
              d_we    = 1'b1;
              d_waddr = 5'd31;
              d_alu   = alu_onehot(ALU_ADD);
            end
          end
          default: ;
        endcase
      end
      OP_BLEZ: if (rt == '0) begin rs_used = 1'b1; d_br = rs_val[31] | (rs_val == '0); d_tgt = b_tgt; end
      OP_BGTZ: if (rt == '0) begin rs_used = 1'b1; d_br = !rs_val[31] && (rs_val != '0); d_tgt = b_tgt; end
`endif
      default: ;
    endcase
  end

  logic sb_rs_hit, sb_rt_hit, issue_ok;

  id_load_sb #(.LOAD_LAT(LOAD_LAT)) u_load_sb (
    .clk      (clk),
    .rst      (rst),
    .advance  (!ex_stall),
    .ld_issue (issue_ok & d_load),
    .ld_waddr (d_waddr),
    .q0_addr  (rs),
    .q1_addr  (rt),
    .q0_hit   (sb_rs_hit),
    .q1_hit   (sb_rt_hit)
  );

  assign stallreq = id_valid & ((rs_used & sb_rs_hit) | (rt_used & sb_rt_hit));
  assign issue_ok = id_valid & ~stallreq;

  // An empty slot presents all-zero fields; an interlocked slot keeps its fields but has no side effects
  assign ex.ex_valid    = issue_ok;
  assign ex.ex_pc       = id_valid ? id_pc : '0;
  assign ex.ex_inst     = id_valid ? inst : '0;
  assign ex.ex_alu_op   = id_valid ? d_alu : '0;
  assign ex.ex_rf_we    = issue_ok & d_we & (d_waddr != '0);
  assign ex.ex_rf_waddr = id_valid ? d_waddr : '0;
  assign ex.ex_is_load  = id_valid & d_load;
  assign ex.ex_mem_we   = issue_ok & d_mem_we;
  assign ex.ex_rs_val   = id_valid ? rs_val : '0;
  assign ex.ex_rt_val   = id_valid ? rt_val : '0;
  assign ex.br_taken    = issue_ok & d_br;
  assign ex.br_target   = id_valid ? d_tgt : '0;

endmodule

// File: tb/tb_id_stage_v2.sv
// tb/tb_id_stage_v2.sv - directed scoreboard bench for id_stage_v2 (LOAD_LAT=2, NUM_FWD=3)
module tb_id_stage_v2;
  localparam int NUM_FWD  = 3;
  localparam int LOAD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, id_stall, id_flush, ex_stall, if_valid;
  logic [31:0]           if_pc, inst_rdata;
  logic [NUM_FWD-1:0]    fwd_we;
  logic [5*NUM_FWD-1:0]  fwd_waddr;
  logic [32*NUM_FWD-1:0] fwd_wdata;
  logic                  wb_we;
  logic [4:0]            wb_waddr;
  logic [31:0]           wb_wdata;
  logic                  stallreq;

  id_stage_v2_if ex ();

  id_stage_v2 #(.NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .id_flush(id_flush), .ex_stall(ex_stall),
    .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .ex(ex)
  );

  typedef enum int {K_VALID, K_PC, K_INST, K_ALU, K_WE, K_WADDR, K_LOAD,
                    K_RS, K_RT, K_BR, K_TGT, K_STALL, K_HOLD} kind_e;
  typedef struct { string tag; kind_e kind; logic [31:0] val; } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_VALID: return {31'b0, ex.ex_valid};
      K_PC:    return ex.ex_pc;
      K_INST:  return ex.ex_inst;
      K_ALU:   return {20'b0, ex.ex_alu_op};
      K_WE:    return {31'b0, ex.ex_rf_we};
      K_WADDR: return {27'b0, ex.ex_rf_waddr};
      K_LOAD:  return {31'b0, ex.ex_is_load};
      K_RS:    return ex.ex_rs_val;
      K_RT:    return ex.ex_rt_val;
      K_BR:    return {31'b0, ex.br_taken};
      K_TGT:   return ex.br_target;
      K_STALL: return {31'b0, stallreq};
      default: return {31'b0, dut.hold_vld};
    endcase
  endfunction

  task automatic sb_push(string tag, kind_e k, logic [31:0] v);
    sbq.push_back('{tag, k, v});
  endtask

  task automatic check_all();
    #1;
    while (sbq.size() > 0) begin
      exp_t        e = sbq.pop_front();
      logic [31:0] o = observe(e.kind);
      n_tests++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(int i, logic we, logic [4:0] a, logic [31:0] d);
    fwd_we[i]          = we;
    fwd_waddr[5*i +: 5]  = a;
    fwd_wdata[32*i +: 32] = d;
  endtask

  task automatic wb_write(logic [4:0] a, logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    tick();
    wb_we = 1'b0;
  endtask

  function automatic logic [31:0] r_type(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [31:0] w_addu, w_lw, w_ori;

  initial begin
    rst = 1'b1; id_stall = 1'b0; id_flush = 1'b0; ex_stall = 1'b0;
    if_valid = 1'b1; if_pc = 32'h40; inst_rdata = 32'h2108_0001;
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    tick(); tick();
    sb_push("rst_valid", K_VALID, 0); sb_push("rst_pc", K_PC, 0); sb_push("rst_inst", K_INST, 0);
    sb_push("rst_alu", K_ALU, 0); sb_push("rst_we", K_WE, 0); sb_push("rst_br", K_BR, 0);
    sb_push("rst_stall", K_STALL, 0); sb_push("rst_hold", K_HOLD, 0);
    check_all();

    rst = 1'b0; if_valid = 1'b0;
    wb_write(5'd1, 32'd7); wb_write(5'd2, 32'd7); wb_write(5'd5, 32'h55);

    // forwarding priority: fwd0 > fwd2 > WB > regfile, r0 reads zero
    w_addu = r_type(5'd5, 5'd5, 5'd6, 6'h21);
    if_valid = 1'b1; if_pc = 32'h100;
    tick();
    inst_rdata = w_addu;
    set_fwd(0, 1'b1, 5'd5, 32'h11); set_fwd(2, 1'b1, 5'd5, 32'h22);
    sb_push("fwd_valid", K_VALID, 1); sb_push("fwd_pc", K_PC, 32'h100);
    sb_push("fwd_pri_rs", K_RS, 32'h11); sb_push("fwd_pri_rt", K_RT, 32'h11);
    sb_push("addu_alu", K_ALU, 32'h800); sb_push("addu_we", K_WE, 1); sb_push("addu_waddr", K_WADDR, 6);
    check_all();
    set_fwd(0, 1'b0, 5'd0, 32'h0);
    sb_push("fwd2_rs", K_RS, 32'h22); check_all();
    set_fwd(2, 1'b0, 5'd0, 32'h0);
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h33;
    sb_push("wb_rs", K_RS, 32'h33); check_all();
    wb_we = 1'b0;
    sb_push("rf_rs", K_RS, 32'h55); check_all();
    set_fwd(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    inst_rdata = r_type(5'd0, 5'd5, 5'd6, 6'h21);
    sb_push("r0_rs", K_RS, 32'h0); check_all();
    set_fwd(1, 1'b0, 5'd0, 32'h0);

    // branch / jump resolution in ID
    if_pc = 32'h1000;
    tick();
    inst_rdata = i_type(6'h04, 5'd1, 5'd2, 16'd4);
    sb_push("beq_taken", K_BR, 1); sb_push("beq_tgt", K_TGT, 32'h1014); sb_push("beq_we", K_WE, 0);
    check_all();
    set_fwd(0, 1'b1, 5'd2, 32'd8);
    sb_push("beq_not_taken", K_BR, 0); check_all();
    set_fwd(0, 1'b0, 5'd0, 32'h0);

    if_pc = 32'h3000_0010;
    tick();
    inst_rdata = {6'h03, 26'h40};
    sb_push("jal_br", K_BR, 1); sb_push("jal_tgt", K_TGT, 32'h3000_0100);
    sb_push("jal_we", K_WE, 1); sb_push("jal_waddr", K_WADDR, 31); sb_push("jal_alu", K_ALU, 32'h800);
    check_all();
    inst_rdata = {6'h3f, 26'h0};
    sb_push("nop_we", K_WE, 0); sb_push("nop_br", K_BR, 0); sb_push("nop_alu", K_ALU, 0);
    sb_push("nop_valid", K_VALID, 1);
    check_all();

    // load-use interlock with LOAD_LAT=2: two bubble cycles then issue
    w_lw   = i_type(6'h23, 5'd1, 5'd3, 16'h0);
    w_addu = r_type(5'd3, 5'd3, 5'd4, 6'h21);
    if_pc = 32'h200;
    tick();
    inst_rdata = w_lw;
    sb_push("lw_valid", K_VALID, 1); sb_push("lw_load", K_LOAD, 1); sb_push("lw_stall", K_STALL, 0);
    sb_push("lw_we", K_WE, 1); sb_push("lw_waddr", K_WADDR, 3);
    check_all();
    if_pc = 32'h204;
    tick();
    inst_rdata = w_addu;
    sb_push("lu_stall1", K_STALL, 1); sb_push("lu_valid1", K_VALID, 0); sb_push("lu_we1", K_WE, 0);
    check_all();
    id_stall = 1'b1;
    tick();
    inst_rdata = 32'hFFFF_FFFF;
    sb_push("lu_stall2", K_STALL, 1); sb_push("lu_valid2", K_VALID, 0); sb_push("lu_inst2", K_INST, w_addu);
    check_all();
    tick();
    id_stall = 1'b0;
    sb_push("lu_stall3", K_STALL, 0); sb_push("lu_valid3", K_VALID, 1); sb_push("lu_we3", K_WE, 1);
    sb_push("lu_waddr3", K_WADDR, 4); sb_push("lu_inst3", K_INST, w_addu); sb_push("lu_pc3", K_PC, 32'h204);
    check_all();

    // hold buffer across a 3-cycle stall with garbage on the SRAM bus
    w_ori = i_type(6'h0d, 5'd0, 5'd7, 16'h55);
    if_pc = 32'h400;
    tick();
    inst_rdata = w_ori;
    sb_push("ori_inst", K_INST, w_ori); sb_push("ori_waddr", K_WADDR, 7); check_all();
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      inst_rdata = 32'hDEAD_0000 + 32'(i);
      sb_push("hold_inst", K_INST, w_ori); sb_push("hold_vld", K_HOLD, 1);
      check_all();
    end
    id_stall = 1'b0;
    sb_push("release_inst", K_INST, w_ori); check_all();
    if_pc = 32'h404;
    tick();
    inst_rdata = i_type(6'h0e, 5'd0, 5'd8, 16'h1);
    sb_push("new_inst", K_INST, i_type(6'h0e, 5'd0, 5'd8, 16'h1));
    sb_push("new_pc", K_PC, 32'h404); sb_push("new_hold", K_HOLD, 0);
    check_all();

    // flush and stall together: bubble wins, hold buffer cleared
    if_pc = 32'h500;
    tick();
    inst_rdata = i_type(6'h09, 5'd1, 5'd9, 16'h1);
    sb_push("pre_flush_valid", K_VALID, 1); check_all();
    id_stall = 1'b1;
    tick();
    sb_push("pre_flush_hold", K_HOLD, 1); check_all();
    id_flush = 1'b1;
    tick();
    sb_push("flush_valid", K_VALID, 0); sb_push("flush_hold", K_HOLD, 0); check_all();
    id_flush = 1'b0; id_stall = 1'b0;

    // REGIMM link branch: bltzal with rs=-1
    if_pc = 32'h2000;
    tick();
    inst_rdata = i_type(6'h01, 5'd9, 5'd16, 16'd4);
    set_fwd(0, 1'b1, 5'd9, 32'hFFFF_FFFF);
`ifdef BRANCH_EXT_EN
    sb_push("bltzal_br", K_BR, 1); sb_push("bltzal_tgt", K_TGT, 32'h2014);
    sb_push("bltzal_we", K_WE, 1); sb_push("bltzal_waddr", K_WADDR, 31); sb_push("bltzal_alu", K_ALU, 32'h800);
`else
    sb_push("bltzal_nop_br", K_BR, 0); sb_push("bltzal_nop_we", K_WE, 0); sb_push("bltzal_nop_alu", K_ALU, 0);
`endif
    check_all();
    set_fwd(0, 1'b0, 5'd0, 32'h0);

    // reset while interlocked
    if_pc = 32'h600;
    tick();
    inst_rdata = w_lw;
    if_pc = 32'h604;
    tick();
    inst_rdata = w_addu;
    sb_push("pre_rst_stall", K_STALL, 1); check_all();
    rst = 1'b1; id_stall = 1'b1;
    tick();
    sb_push("mid_rst_stall", K_STALL, 0); sb_push("mid_rst_valid", K_VALID, 0); sb_push("mid_rst_hold", K_HOLD, 0);
    check_all();
    rst = 1'b0; id_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
